// File: rtl/rst_seq_ctrl.sv
// Board reset sequencer: holds NumRst active-low resets until PLL lock and the
// button settle, releases them in ascending order and records the last cause.
module rst_seq_ctrl #(
  parameter int NumRst         = 4,
  parameter int PorCycles      = 256,
  parameter int ReleaseGap     = 16,
  parameter int DebounceCycles = 1024,
  parameter bit PllLossRst     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pll_locked_i,
  input  logic              rst_btn_i,
  input  logic              sw_rst_req_i,
  output logic [NumRst-1:0] rst_no,
  output logic [2:0]        rst_cause_o,
  output logic              done_o
);

  // state     | meaning
  // WAIT_LOCK | all resets held, waiting for lock and a released button
  // POR_COUNT | lock stable, counting PorCycles before the first release
  // RELEASE   | releasing one reset every ReleaseGap cycles
  // RUN       | all resets released, watching for reset events
  typedef enum logic [1:0] {WAIT_LOCK, POR_COUNT, RELEASE, RUN} state_e;

  localparam int CntW = (PorCycles > 1) ? $clog2(PorCycles) : 1;
  localparam int GapW = (ReleaseGap > 1) ? $clog2(ReleaseGap) : 1;
  localparam int DbW  = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int IdxW = (NumRst > 1) ? $clog2(NumRst) : 1;

  localparam logic [CntW-1:0] PorLast = CntW'(PorCycles - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(ReleaseGap - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DebounceCycles - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumRst - 1);

  logic lock_m_q, lock_s_q, btn_m_q, btn_s_q;
  logic btn_db_q, btn_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  state_e state_q, state_d;
  logic [CntW-1:0]   por_cnt_q, por_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NumRst-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic [2:0]        cause_q, cause_d;

  logic       btn_rise;
  logic       lock_loss;
  logic [2:0] rst_event;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      btn_m_q  <= 1'b0;
      btn_s_q  <= 1'b0;
    end else begin
      lock_m_q <= pll_locked_i;
      lock_s_q <= lock_m_q;
      btn_m_q  <= rst_btn_i;
      btn_s_q  <= btn_m_q;
    end
  end

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (btn_s_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      btn_db_d = ~btn_db_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign btn_rise  = btn_db_d & ~btn_db_q;
  // Lock is always high on entry to RELEASE, so low there means it just fell.
  assign lock_loss = PllLossRst & ~lock_s_q;
  assign rst_event = {sw_rst_req_i, btn_rise, lock_loss};

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    done_d    = done_q;
    cause_d   = cause_q;
    unique case (state_q)
      WAIT_LOCK: begin
        rst_d     = '0;
        done_d    = 1'b0;
        por_cnt_d = '0;
        if (lock_s_q && !btn_db_q) state_d = POR_COUNT;
      end
      POR_COUNT: begin
        if (!lock_s_q || btn_db_q) begin
          state_d   = WAIT_LOCK;
          por_cnt_d = '0;
        end else if (por_cnt_q == PorLast) begin
          rst_d[0]  = 1'b1;
          idx_d     = '0;
          gap_cnt_d = '0;
          if (NumRst == 1) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          por_cnt_d = por_cnt_q + CntW'(1);
        end
      end
      RELEASE, RUN: begin
        if (|rst_event) begin
          rst_d     = '0;
          done_d    = 1'b0;
          cause_d   = rst_event;
          por_cnt_d = '0;
          state_d   = WAIT_LOCK;
        end else if (state_q == RELEASE) begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_d    = '0;
            idx_d        = idx_q + IdxW'(1);
            rst_d[idx_d] = 1'b1;
            if (idx_d == IdxLast) begin
              done_d  = 1'b1;
              state_d = RUN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q  <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= WAIT_LOCK;
      por_cnt_q <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      rst_q     <= '0;
      done_q    <= 1'b0;
      cause_q   <= 3'b001;
    end else begin
      btn_db_q  <= btn_db_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      por_cnt_q <= por_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_no      = rst_q;
  assign done_o      = done_q;
  assign rst_cause_o = cause_q;

endmodule
